// File: rtl/div_pkg.sv
// Shared definitions for the divider issue unit: FSM state encodings and the
// per-request operation flags.
package div_pkg;

  localparam int DIV_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic is_signed;
    logic rem;
  } op_flags_t;

endpackage

// File: rtl/div_issue_unit_if.sv
// Request/response bus of the divider issue unit. Both channels use valid/ready:
// a transfer happens on a rising clock edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge.
interface div_issue_unit_if #(parameter int W = 16);

  logic         req_valid;
  logic         req_ready;
  logic         req_signed;
  logic         req_rem;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_dbz;

  modport master (
    output req_valid, req_signed, req_rem, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_dbz
  );

  modport slave (
    input  req_valid, req_signed, req_rem, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_dbz
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of divider results (all arithmetic mod 2^W).
module div_sign_fix #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/div_issue_unit.sv
// Issue/sign stage in front of the multi-cycle unsigned divider.
// Optional DIV_ZERO_FASTPATH_EN: a zero divisor bypasses the divider entirely.
module div_issue_unit
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic                 clk,
  input  logic                 reset,
  div_issue_unit_if.slave      bus,
  output logic                 div_start,
  output logic [W-1:0]         div_word1,
  output logic [W-1:0]         div_word2,
  input  logic [W-1:0]         div_quotient,
  input  logic [W-1:0]         div_remainder,
  input  logic                 div_ready,
  output logic [2:0]           dbg_state
);

  logic [2:0]   r_state;
  op_flags_t    r_flags;
  logic         r_sign_a;
  logic         r_sign_b;
  logic [W-1:0] r_word1;
  logic [W-1:0] r_word2;
  logic [W-1:0] r_rsp_data;
  logic         r_rsp_valid;
  logic         r_rsp_dbz;

  logic         w_accept;
  logic         w_neg_a;
  logic         w_neg_b;
  logic         w_b_zero;
  logic         w_fix_q;
  logic         w_fix_r;
  logic [W-1:0] w_mag_a;
  logic [W-1:0] w_mag_b;
  logic [W-1:0] w_q;
  logic [W-1:0] w_r;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  assign w_neg_a  = bus.req_signed & bus.req_a[W-1];
  assign w_neg_b  = bus.req_signed & bus.req_b[W-1];
  assign w_b_zero = (bus.req_b == '0);

  // Raw sign bits are kept; unsigned requests mask them out here.
  assign w_fix_q = r_flags.is_signed & (r_sign_a ^ r_sign_b);
  assign w_fix_r = r_flags.is_signed & r_sign_a;

  div_sign_fix #(.W(W)) u_mag_a (.i_val(bus.req_a),     .i_neg(w_neg_a), .o_val(w_mag_a));
  div_sign_fix #(.W(W)) u_mag_b (.i_val(bus.req_b),     .i_neg(w_neg_b), .o_val(w_mag_b));
  div_sign_fix #(.W(W)) u_fix_q (.i_val(div_quotient),  .i_neg(w_fix_q), .o_val(w_q));
  div_sign_fix #(.W(W)) u_fix_r (.i_val(div_remainder), .i_neg(w_fix_r), .o_val(w_r));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_word1     <= '0;
      r_word2     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_flags.is_signed <= bus.req_signed;
            r_flags.rem       <= bus.req_rem;
            r_sign_a          <= bus.req_a[W-1];
            r_sign_b          <= bus.req_b[W-1];
            r_word1           <= w_mag_a;
            r_word2           <= w_mag_b;
            r_rsp_dbz         <= w_b_zero;
`ifdef DIV_ZERO_FASTPATH_EN
            if (w_b_zero) begin
              r_rsp_data  <= bus.req_rem ? bus.req_a : '1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_START;
            end
`else
            r_state <= ST_START;
`endif
          end
        end
        ST_START: r_state <= ST_ARM;
        // The divider may still report ready for a cycle after the start pulse.
        ST_ARM:   r_state <= ST_WAIT;
        ST_WAIT: begin
          if (div_ready) begin
            r_rsp_data  <= r_flags.rem ? w_r : w_q;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_dbz   = r_rsp_dbz;
  assign div_start     = (r_state == ST_START);
  assign div_word1     = r_word1;
  assign div_word2     = r_word2;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_div_issue_unit.sv
// Bench for div_issue_unit: table of directed divide requests plus hand-written
// back-pressure and mid-operation reset sequences, against a behavioural divider.
module tb_div_issue_unit;
  import div_pkg::*;

  localparam int W    = 16;
  localparam int BUSY = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_issue_unit_if #(.W(W)) bus();

  logic         div_start;
  logic         div_ready;
  logic [W-1:0] div_word1;
  logic [W-1:0] div_word2;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic [2:0]   dbg_state;

  div_issue_unit #(.W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .div_start     (div_start),
    .div_word1     (div_word1),
    .div_word2     (div_word2),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_ready     (div_ready),
    .dbg_state     (dbg_state)
  );

  // Behavioural divider: ready drops after start, results appear BUSY cycles later.
  int busy_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt      <= 0;
      div_ready     <= 1'b1;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      busy_cnt  <= BUSY;
      div_ready <= 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        div_ready <= 1'b1;
        if (div_word2 == '0) begin
          div_quotient  <= '1;
          div_remainder <= div_word1;
        end else begin
          div_quotient  <= div_word1 / div_word2;
          div_remainder <= div_word1 % div_word2;
        end
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         s;
    logic         rem;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_w1;
    logic [W-1:0] exp_w2;
    logic         exp_dbz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic s, input logic rem, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_signed = s;
    bus.req_rem    = rem;
    bus.req_a      = a;
    bus.req_b      = b;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("rsp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_consume", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_after_consume", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int base;
    int lat;
    int exp_starts;
    logic [W-1:0] exp_d;
    base = start_cnt;
    exp_q.push_back(v.exp_data);
`ifdef DIV_ZERO_FASTPATH_EN
    exp_starts = (v.b == '0) ? 0 : 1;
`else
    exp_starts = 1;
`endif
    send_req(v.s, v.rem, v.a, v.b);
    wait_rsp(lat);
    exp_d = exp_q.pop_front();
    check($sformatf("v%0d_rsp_data", idx), 32'(bus.rsp_data), 32'(exp_d));
    check($sformatf("v%0d_rsp_dbz", idx), 32'(bus.rsp_dbz), 32'(v.exp_dbz));
    check($sformatf("v%0d_div_word1", idx), 32'(div_word1), 32'(v.exp_w1));
    check($sformatf("v%0d_div_word2", idx), 32'(div_word2), 32'(v.exp_w2));
    check($sformatf("v%0d_start_pulses", idx), 32'(start_cnt - base), 32'(exp_starts));
`ifdef DIV_ZERO_FASTPATH_EN
    if (v.b == '0) check($sformatf("v%0d_fast_latency", idx), 32'(lat), 32'd1);
`endif
    consume();
  endtask

  initial begin
    int lat;
    int base;
    logic [W-1:0] held;
    vecs[0]  = '{1'b0, 1'b0, 16'd100,  16'd7,   16'h000E, 16'd100,  16'd7,   1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'hFF9C, 16'd7,   16'hFFFE, 16'd100,  16'd7,   1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'hFF9C, 16'd7,   16'hFFF2, 16'd100,  16'd7,   1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h0001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h1234, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'd100,  16'hFFF9, 16'hFFF2, 16'd100,  16'd7,   1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'd100,  16'hFFF9, 16'h0002, 16'd100,  16'd7,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 16'd2,   16'h7FFF, 16'hFFFF, 16'd2,   1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'hFFFF, 16'd2,   16'h0001, 16'hFFFF, 16'd2,   1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'hFFF9, 16'hFFFE, 16'hFFFF, 16'd7,    16'd2,   1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_rem    = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;
    reset          = 1'b1;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_dbz", 32'(bus.rsp_dbz), 32'd0);
    check("reset_div_start", 32'(div_start), 32'd0);
    check("reset_div_word1", 32'(div_word1), 32'd0);
    check("reset_div_word2", 32'(div_word2), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Back-pressure: result held for 5 cycles while a second request is offered.
    base = start_cnt;
    send_req(1'b0, 1'b0, 16'd1000, 16'd10);
    wait_rsp(lat);
    held = bus.rsp_data;
    check("bp_first_data", 32'(held), 32'h0064);
    bus.req_valid  = 1'b1;
    bus.req_signed = 1'b0;
    bus.req_rem    = 1'b0;
    bus.req_a      = 16'd9;
    bus.req_b      = 16'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_rsp_valid_c%0d", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_rsp_data_c%0d", i), 32'(bus.rsp_data), 32'h0064);
      check($sformatf("bp_req_ready_c%0d", i), 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    check("bp_start_pulses", 32'(start_cnt - base), 32'd1);
    consume();
    @(negedge clk);
    check("bp_no_late_accept", 32'(dbg_state), 32'(ST_IDLE));

    // Reset while waiting on the divider, then a fresh request.
    send_req(1'b0, 1'b0, 16'd50, 16'd5);
    for (int i = 0; i < 10; i++) begin
      if (dbg_state == ST_WAIT) break;
      @(negedge clk);
    end
    check("rst_reached_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    run_vec('{1'b0, 1'b0, 16'd50, 16'd5, 16'd10, 16'd50, 16'd5, 1'b0}, 100);
    run_vec('{1'b1, 1'b1, 16'hFFCE, 16'd7, 16'hFFFF, 16'd50, 16'd7, 1'b0}, 101);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
